// File: rtl/instr_queue.sv
// instr_queue: first-word fall-through decoupling FIFO between fetch and decode.
// Define INSTR_QUEUE_BYPASS_EN for a zero-latency path through an empty queue.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic [ILEN-1:0]          fetch_instr_i,
  input  logic                     fetch_pred_taken_i,
  input  logic [XLEN-1:0]          fetch_pred_target_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [XLEN-1:0]          issue_pc_o,
  output logic [ILEN-1:0]          issue_instr_o,
  output logic                     issue_pred_taken_o,
  output logic [XLEN-1:0]          issue_pred_target_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [ILEN-1:0] NOP      = ILEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            taken;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            full_r;
  logic            empty_r;

  logic            push_s;
  logic            pop_s;
  logic            bypass_s;
  logic [CW-1:0]   count_next_s;
  entry_t          fetch_entry_s;
  entry_t          head_s;

  assign fetch_entry_s = '{pc: fetch_pc_i, instr: fetch_instr_i,
                           taken: fetch_pred_taken_i, target: fetch_pred_target_i};
  assign head_s        = mem_r[rd_ptr_r];

  assign fetch_ready_o = !full_r;
  assign count_o       = count_r;
  assign full_o        = full_r;
  assign empty_o       = empty_r;

  // Handshake qualification; flush drops any push or pop in its cycle.
  always_comb begin
    push_s   = 1'b0;
    pop_s    = 1'b0;
    bypass_s = 1'b0;
    if (flush_i) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
`ifdef INSTR_QUEUE_BYPASS_EN
      bypass_s = empty_r && fetch_valid_i && issue_ready_i;
`endif
      push_s = fetch_valid_i && !full_r && !bypass_s;
      pop_s  = !empty_r && issue_ready_i;
    end
  end

  // Occupancy update for the non-flush case.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer, count and status flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else if (flush_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_FULL);
      empty_r <= (count_next_s == CNT_ZERO);
    end
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= fetch_entry_s;
    end
  end

  // Head presentation; an empty queue shows a masked NOP, never stale data.
  always_comb begin
    issue_valid_o       = 1'b0;
    issue_pc_o          = {XLEN{1'b0}};
    issue_instr_o       = NOP;
    issue_pred_taken_o  = 1'b0;
    issue_pred_target_o = {XLEN{1'b0}};
    if (!empty_r) begin
      issue_valid_o       = 1'b1;
      issue_pc_o          = head_s.pc;
      issue_instr_o       = head_s.instr;
      issue_pred_taken_o  = head_s.taken;
      issue_pred_target_o = head_s.target;
    end
`ifdef INSTR_QUEUE_BYPASS_EN
    else if (!flush_i && fetch_valid_i) begin
      issue_valid_o       = 1'b1;
      issue_pc_o          = fetch_pc_i;
      issue_instr_o       = fetch_instr_i;
      issue_pred_taken_o  = fetch_pred_taken_i;
      issue_pred_target_o = fetch_pred_target_i;
    end
`endif
    else begin
      issue_valid_o       = 1'b0;
      issue_pc_o          = {XLEN{1'b0}};
      issue_instr_o       = NOP;
      issue_pred_taken_o  = 1'b0;
      issue_pred_target_o = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (default and bypass builds).
module tb_instr_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [63:0] fetch_pc_i;
  logic [31:0] fetch_instr_i;
  logic        fetch_pred_taken_i;
  logic [63:0] fetch_pred_target_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [63:0] issue_pc_o;
  logic [31:0] issue_instr_o;
  logic        issue_pred_taken_o;
  logic [63:0] issue_pred_target_o;
  logic [3:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int n_checks = 0;
  int n_errors = 0;

  instr_queue #(.DEPTH(8), .XLEN(64), .ILEN(32)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_instr_i       (fetch_instr_i),
    .fetch_pred_taken_i  (fetch_pred_taken_i),
    .fetch_pred_target_i (fetch_pred_target_i),
    .issue_valid_o       (issue_valid_o),
    .issue_ready_i       (issue_ready_i),
    .issue_pc_o          (issue_pc_o),
    .issue_instr_o       (issue_instr_o),
    .issue_pred_taken_o  (issue_pred_taken_o),
    .issue_pred_target_o (issue_pred_target_o),
    .count_o             (count_o),
    .full_o              (full_o),
    .empty_o             (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] instr,
                       input logic taken, input logic [63:0] target);
    fetch_valid_i       = 1'b1;
    fetch_pc_i          = pc;
    fetch_instr_i       = instr;
    fetch_pred_taken_i  = taken;
    fetch_pred_target_i = target;
  endtask

  initial begin
    int rd_idx;
    int wr_idx;
    rst_i = 1'b1;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pc_i = 64'h0;
    fetch_instr_i = 32'h0;
    fetch_pred_taken_i = 1'b0;
    fetch_pred_target_i = 64'h0;
    issue_ready_i = 1'b0;
    #2;
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_empty", 64'(empty_o), 64'd1);
    check_eq("rst_full", 64'(full_o), 64'd0);
    check_eq("rst_valid", 64'(issue_valid_o), 64'd0);
    check_eq("rst_ready", 64'(fetch_ready_o), 64'd1);
    check_eq("rst_nop", 64'(issue_instr_o), 64'h13);
    check_eq("rst_pc", issue_pc_o, 64'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // single push, visible the cycle after
    check_eq("pre_push_nop", 64'(issue_instr_o), 64'h13);
    offer(64'h1000, 32'h0050_0093, 1'b1, 64'h1100);
    tick();
    fetch_valid_i = 1'b0;
    check_eq("p1_valid", 64'(issue_valid_o), 64'd1);
    check_eq("p1_pc", issue_pc_o, 64'h1000);
    check_eq("p1_instr", 64'(issue_instr_o), 64'h0050_0093);
    check_eq("p1_taken", 64'(issue_pred_taken_o), 64'd1);
    check_eq("p1_target", issue_pred_target_o, 64'h1100);
    check_eq("p1_count", 64'(count_o), 64'd1);
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
    check_eq("p1_drained", 64'(empty_o), 64'd1);
    check_eq("p1_count0", 64'(count_o), 64'd0);

    // fill to full, hold off a ninth, then drain in order
    for (int i = 0; i < 8; i++) begin
      offer(64'(i * 4), 32'(32'h100 + i), 1'(i % 2), 64'(64'h8000 + i * 4));
      tick();
    end
    check_eq("fill_full", 64'(full_o), 64'd1);
    check_eq("fill_ready", 64'(fetch_ready_o), 64'd0);
    check_eq("fill_count", 64'(count_o), 64'd8);
    offer(64'h20, 32'h0000_0bad, 1'b0, 64'h0);
    tick();
    check_eq("ninth_held", 64'(count_o), 64'd8);
    fetch_valid_i = 1'b0;
    issue_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_valid", 64'(issue_valid_o), 64'd1);
      check_eq("drain_pc", issue_pc_o, 64'(i * 4));
      check_eq("drain_instr", 64'(issue_instr_o), 64'(32'h100 + i));
      check_eq("drain_taken", 64'(issue_pred_taken_o), 64'(i % 2));
      check_eq("drain_target", issue_pred_target_o, 64'(64'h8000 + i * 4));
      tick();
    end
    issue_ready_i = 1'b0;
    check_eq("drain_empty", 64'(empty_o), 64'd1);
    check_eq("drain_valid0", 64'(issue_valid_o), 64'd0);
    check_eq("drain_pc0", issue_pc_o, 64'h0);

    // steady-state push+pop at count 3 with pointer wrap
    for (int k = 0; k < 3; k++) begin
      offer(64'(64'h100 + k * 4), 32'(k), 1'b0, 64'h0);
      tick();
    end
    rd_idx = 0;
    wr_idx = 3;
    for (int c = 0; c < 20; c++) begin
      offer(64'(64'h100 + wr_idx * 4), 32'(wr_idx), 1'b0, 64'h0);
      issue_ready_i = 1'b1;
      check_eq("stream_pc", issue_pc_o, 64'(64'h100 + rd_idx * 4));
      check_eq("stream_count", 64'(count_o), 64'd3);
      tick();
      rd_idx++;
      wr_idx++;
    end
    fetch_valid_i = 1'b0;
    issue_ready_i = 1'b0;
    check_eq("stream_end_count", 64'(count_o), 64'd3);
    check_eq("stream_end_pc", issue_pc_o, 64'(64'h100 + rd_idx * 4));

    // flush at count 5 beats a simultaneous push and pop
    for (int k = 0; k < 2; k++) begin
      offer(64'(64'h100 + wr_idx * 4), 32'(wr_idx), 1'b0, 64'h0);
      tick();
      wr_idx++;
    end
    fetch_valid_i = 1'b0;
    check_eq("pre_flush_count", 64'(count_o), 64'd5);
    offer(64'hDEAD0, 32'hDEAD, 1'b1, 64'hBEEF);
    issue_ready_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    issue_ready_i = 1'b0;
    check_eq("flush_count", 64'(count_o), 64'd0);
    check_eq("flush_valid", 64'(issue_valid_o), 64'd0);
    check_eq("flush_empty", 64'(empty_o), 64'd1);
    tick();
    check_eq("flush_no_ghost_valid", 64'(issue_valid_o), 64'd0);
    check_eq("flush_no_ghost_pc", issue_pc_o, 64'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_eq("flush_idle_count", 64'(count_o), 64'd0);

    // asynchronous reset mid-cycle at count 4
    for (int k = 0; k < 4; k++) begin
      offer(64'(64'h300 + k * 4), 32'(k), 1'b0, 64'h0);
      tick();
    end
    fetch_valid_i = 1'b0;
    check_eq("pre_arst_count", 64'(count_o), 64'd4);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("arst_count", 64'(count_o), 64'd0);
    check_eq("arst_valid", 64'(issue_valid_o), 64'd0);
    check_eq("arst_ready", 64'(fetch_ready_o), 64'd1);
    #1;
    rst_i = 1'b0;
    tick();

    // empty queue with both sides ready
    offer(64'h2000, 32'h0000_0013, 1'b0, 64'h0);
    issue_ready_i = 1'b1;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    check_eq("byp_valid", 64'(issue_valid_o), 64'd1);
    check_eq("byp_pc", issue_pc_o, 64'h2000);
    check_eq("byp_count", 64'(count_o), 64'd0);
    tick();
    fetch_valid_i = 1'b0;
    check_eq("byp_after_count", 64'(count_o), 64'd0);
    check_eq("byp_after_empty", 64'(empty_o), 64'd1);
`else
    check_eq("nobyp_valid", 64'(issue_valid_o), 64'd0);
    check_eq("nobyp_count", 64'(count_o), 64'd0);
    tick();
    fetch_valid_i = 1'b0;
    check_eq("nobyp_next_valid", 64'(issue_valid_o), 64'd1);
    check_eq("nobyp_next_pc", issue_pc_o, 64'h2000);
    check_eq("nobyp_next_count", 64'(count_o), 64'd1);
    tick();
    check_eq("nobyp_popped", 64'(count_o), 64'd0);
`endif
    issue_ready_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
